// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        OUTPUT
    } acc_state_t;

    // Width of an operand counter that must be able to hold MAX_OPS itself.
    function automatic int cnt_width(input int max_ops);
        return $clog2(max_ops) + 1;
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / result-out handshake bundle for the stream accumulator.
// The slave view belongs to the accumulator, the master view to whoever drives it.
interface csa_stream_accumulator_if #(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 4,
    parameter int SUM_W   = 7
);
    import csa_pkg::*;

    localparam int CNT_W = cnt_width(MAX_OPS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_trunc
    );

endinterface

// File: rtl/csa_stream_accumulator_3to2.sv
// Bitwise 3:2 compressor (full-adder row). The carry is returned unshifted;
// the caller aligns it to the next bit position.
module csa_3to2 #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] cin,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder. Operands are folded into a sum/carry pair
// through one 3:2 compressor; a single carry-propagate add resolves the total
// once the packet closes (in_last, or the MAX_OPS-th operand).
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 4,
    parameter int SUM_W   = 7
) (
    input logic                    clk,
    input logic                    rst,
    csa_stream_accumulator_if.slave bus
);

    localparam int CNT_W = cnt_width(MAX_OPS);

    if (SUM_W < WIDTH + $clog2(MAX_OPS)) begin : g_sum_w_check
        $error("csa_stream_accumulator: SUM_W too narrow for WIDTH and MAX_OPS");
    end

    acc_state_t       state_q;
    acc_state_t       state_d;
    logic [SUM_W-1:0] s_q;
    logic [SUM_W-1:0] c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trunc_q;
    logic [SUM_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_trunc_q;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept;
    logic             last_slot;
    logic [SUM_W-1:0] x_ext;
    logic [SUM_W-1:0] csa_sum;
    logic [SUM_W-1:0] csa_carry;
    logic [SUM_W-1:0] c_next;

    assign accept    = bus.in_valid && (state_q == ACCUM);
    assign last_slot = (cnt_q == CNT_W'(MAX_OPS - 1));
    assign x_ext     = SUM_W'(bus.in_data);
    // SUM_W leaves headroom for the full packet, so the bit shifted out is always zero.
    assign c_next    = csa_carry << 1;

    csa_3to2 #(.W(SUM_W)) u_csa (
        .a     (s_q),
        .b     (c_q),
        .cin   (x_ext),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready_c = 1'b1;
                if (accept && (bus.in_last || last_slot)) state_d = RESOLVE;
            end
            RESOLVE: state_d = OUTPUT;
            OUTPUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // Carry-save accumulation, resolution add, and per-packet clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        s_q   <= csa_sum;
                        c_q   <= c_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_slot) trunc_q <= ~bus.in_last;
                    end
                end
                RESOLVE: begin
                    out_sum_q   <= s_q + c_q;
                    out_count_q <= cnt_q;
                    out_trunc_q <= trunc_q;
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        s_q     <= '0;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        trunc_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_trunc = out_trunc_q;

endmodule
